// File: rtl/btb_pkg.sv
// Shared BTB definitions: geometry defaults, sequencer state, update entry, PC slicing.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package btb_pkg;

  localparam int IDX_W      = 10;
  localparam int TAG_W      = 30 - IDX_W;
  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 8;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } upd_entry_t;

  // Word-aligned PC: index is pc[IDX_W+1:2], tag is pc[31:IDX_W+2].
  function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
    return IDX_W'(pc >> 2);
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return TAG_W'(pc >> (IDX_W + 2));
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// In-order update queue with synchronous clear; pop data is the head, shown combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens the same cycle; pop on empty is ignored.
// Ports: clk, rst_n (sync, active-low), clr, push/push_dat, pop/pop_dat, full, empty, count.
module btb_upd_fifo #(
  parameter int WIDTH = 62,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import btb_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates everything that is read out.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/btb_access_ctrl.sv
// BTB array sequencer: invalidation sweep, lookup/update port arbitration, tag compare.
// Latency: lookup result one cycle after lk_gnt; queued update written when it wins the port.
// Backpressure: upd_ready low when queue full or not in RUN; lookups simply wait for lk_gnt.
// Ports: clk/rst_n (sync, active-low); IF lookup lk_*/pred_*; EX update upd_*; flush_req/flush_busy;
//        single-port array arr_en/we/idx/w* out, arr_r* in (read data valid the cycle after a read).
module btb_access_ctrl #(
  parameter int  IDX_W      = btb_pkg::IDX_W,
  parameter int  FIFO_DEPTH = btb_pkg::FIFO_DEPTH,
  parameter int  STARVE_MAX = btb_pkg::STARVE_MAX,
  localparam int TAG_W      = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_req,
  input  logic [31:0]      lk_pc,
  output logic             lk_gnt,
  output logic             pred_valid,
  output logic             pred_hit,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [31:0]      upd_target,
  output logic             upd_ready,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             arr_en,
  output logic             arr_we,
  output logic [IDX_W-1:0] arr_idx,
  output logic [TAG_W-1:0] arr_wtag,
  output logic [31:0]      arr_wtarget,
  output logic             arr_wvalid,
  input  logic [TAG_W-1:0] arr_rtag,
  input  logic [31:0]      arr_rtarget,
  input  logic             arr_rvalid
);
  import btb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam int ENT_W = IDX_W + TAG_W + 32;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } entry_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             pred_valid_q, pred_valid_d;
  logic [TAG_W-1:0] lk_tag_q, lk_tag_d;

  entry_t           push_ent, head_ent;
  logic             q_push, q_full, q_empty;
  logic [CNT_W-1:0] q_count_unused;

  logic run, starved, do_flush, do_drain, do_grant, hit;

  assign run      = (state_q == RUN);
  assign starved  = (starve_q == STV_W'(STARVE_MAX));

  // Port priority in RUN: flush, full drain, starvation drain, lookup, opportunistic drain.
  assign do_flush = rst_n && run && flush_req;
  assign do_drain = rst_n && run && !flush_req && !q_empty && (q_full || starved || !lk_req);
  assign do_grant = rst_n && run && !flush_req && lk_req && !do_drain;

  assign lk_gnt     = do_grant;
  assign upd_ready  = rst_n && run && !q_full;
  assign q_push     = upd_valid && upd_ready;
  assign flush_busy = (state_q == FLUSH);

  assign push_ent.idx    = IDX_W'(upd_pc >> 2);
  assign push_ent.tag    = TAG_W'(upd_pc >> (IDX_W + 2));
  assign push_ent.target = upd_target;

  btb_upd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_upd_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (do_flush),
    .push     (q_push),
    .push_dat (push_ent),
    .pop      (do_drain),
    .pop_dat  (head_ent),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count_unused)
  );

  always_comb begin
    arr_en      = 1'b0;
    arr_we      = 1'b0;
    arr_idx     = '0;
    arr_wtag    = '0;
    arr_wtarget = '0;
    arr_wvalid  = 1'b0;
    if (rst_n && state_q == FLUSH) begin
      arr_en  = 1'b1;
      arr_we  = 1'b1;
      arr_idx = sweep_cnt_q;
    end else if (do_drain) begin
      arr_en      = 1'b1;
      arr_we      = 1'b1;
      arr_idx     = head_ent.idx;
      arr_wtag    = head_ent.tag;
      arr_wtarget = head_ent.target;
      arr_wvalid  = 1'b1;
    end else if (do_grant) begin
      arr_en  = 1'b1;
      arr_idx = IDX_W'(lk_pc >> 2);
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_cnt_d  = sweep_cnt_q;
    starve_d     = starve_q;
    pred_valid_d = do_grant;
    lk_tag_d     = lk_tag_q;

    if (state_q == FLUSH) begin
      sweep_cnt_d = sweep_cnt_q + IDX_W'(1);
      if (&sweep_cnt_q) state_d = RUN;
    end else if (do_flush) begin
      state_d     = FLUSH;
      sweep_cnt_d = '0;
    end

    if (do_grant) lk_tag_d = TAG_W'(lk_pc >> (IDX_W + 2));

    // Only grants made while updates are waiting count towards starvation.
    if (q_empty || do_drain || do_flush) begin
      starve_d = '0;
    end else if (do_grant && !starved) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FLUSH;
      sweep_cnt_q  <= '0;
      starve_q     <= '0;
      pred_valid_q <= 1'b0;
      lk_tag_q     <= '0;
    end else begin
      state_q      <= state_d;
      sweep_cnt_q  <= sweep_cnt_d;
      starve_q     <= starve_d;
      pred_valid_q <= pred_valid_d;
      lk_tag_q     <= lk_tag_d;
    end
  end

  // Array read data is only meaningful the cycle after a grant.
  assign hit         = pred_valid_q && arr_rvalid && (arr_rtag == lk_tag_q);
  assign pred_valid  = pred_valid_q;
  assign pred_hit    = hit;
  assign pred_target = hit ? arr_rtarget : 32'h0;

endmodule

// File: tb/tb_btb_access_ctrl.sv
// Bench for btb_access_ctrl with a behavioural single-port BTB array model.
// Expected drains and lookup results are queued by the stimulus; monitors pop and compare.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_btb_access_ctrl;
  import btb_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               lk_req = 1'b0;
  logic [31:0]        lk_pc = '0;
  logic               lk_gnt;
  logic               pred_valid, pred_hit;
  logic [31:0]        pred_target;
  logic               upd_valid = 1'b0;
  logic [31:0]        upd_pc = '0;
  logic [31:0]        upd_target = '0;
  logic               upd_ready;
  logic               flush_req = 1'b0;
  logic               flush_busy;
  logic               arr_en, arr_we, arr_wvalid;
  logic [IDX_W-1:0]   arr_idx;
  logic [TAG_W-1:0]   arr_wtag;
  logic [31:0]        arr_wtarget;
  logic [TAG_W-1:0]   arr_rtag = '0;
  logic [31:0]        arr_rtarget = '0;
  logic               arr_rvalid = 1'b0;

  always #5 clk = ~clk;

  btb_access_ctrl dut (
    .clk (clk), .rst_n (rst_n),
    .lk_req (lk_req), .lk_pc (lk_pc), .lk_gnt (lk_gnt),
    .pred_valid (pred_valid), .pred_hit (pred_hit), .pred_target (pred_target),
    .upd_valid (upd_valid), .upd_pc (upd_pc), .upd_target (upd_target), .upd_ready (upd_ready),
    .flush_req (flush_req), .flush_busy (flush_busy),
    .arr_en (arr_en), .arr_we (arr_we), .arr_idx (arr_idx), .arr_wtag (arr_wtag),
    .arr_wtarget (arr_wtarget), .arr_wvalid (arr_wvalid),
    .arr_rtag (arr_rtag), .arr_rtarget (arr_rtarget), .arr_rvalid (arr_rvalid)
  );

  // Single-port array with synchronous read.
  logic [TAG_W-1:0] m_tag [1024];
  logic [31:0]      m_tgt [1024];
  logic             m_vld [1024];
  always @(posedge clk) begin
    if (arr_en) begin
      if (arr_we) begin
        m_tag[arr_idx] <= arr_wtag;
        m_tgt[arr_idx] <= arr_wtarget;
        m_vld[arr_idx] <= arr_wvalid;
      end else begin
        arr_rtag    <= m_tag[arr_idx];
        arr_rtarget <= m_tgt[arr_idx];
        arr_rvalid  <= m_vld[arr_idx];
      end
    end
  end

  typedef struct { logic [IDX_W-1:0] idx; logic [TAG_W-1:0] tag; logic [31:0] tgt; } wr_exp_t;
  typedef struct { logic hit; logic [31:0] tgt; } lk_exp_t;
  wr_exp_t wr_q[$];
  lk_exp_t lk_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drain monitor: every valid write must match the next queued update, in order.
  always @(negedge clk) begin
    wr_exp_t e;
    if (arr_en === 1'b1 && arr_we === 1'b1 && arr_wvalid === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_drain: got write idx=%0h tag=%0h, expected no write", arr_idx, arr_wtag);
      end else begin
        e = wr_q.pop_front();
        check("drain_idx", arr_idx, e.idx);
        check("drain_tag", arr_wtag, e.tag);
        check("drain_target", arr_wtarget, e.tgt);
      end
    end
  end

  // Prediction monitor: every pred_valid must match the next queued lookup.
  always @(negedge clk) begin
    lk_exp_t e;
    if (pred_valid === 1'b1) begin
      if (lk_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_pred: got pred_valid=1, expected 0");
      end else begin
        e = lk_q.pop_front();
        check("pred_hit", pred_hit, e.hit);
        check("pred_target", pred_target, e.tgt);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [IDX_W-1:0] i, input logic [TAG_W-1:0] t, input logic [31:0] g);
    wr_exp_t e;
    e.idx = i; e.tag = t; e.tgt = g;
    wr_q.push_back(e);
  endtask

  task automatic push_lk(input logic h, input logic [31:0] g);
    lk_exp_t e;
    e.hit = h; e.tgt = g;
    lk_q.push_back(e);
  endtask

  task automatic lookup(input logic [31:0] pc, input logic h, input logic [31:0] g, input string nm);
    cyc(); lk_req = 1'b1; lk_pc = pc; push_lk(h, g);
    @(negedge clk); check(nm, lk_gnt, 1);
    cyc(); lk_req = 1'b0;
    @(negedge clk);
  endtask

  // Must be entered so that the next negedge is sweep cycle 0. Lookups and updates are
  // offered throughout and a flush pulse is sent mid-sweep; all must be ignored.
  task automatic run_sweep(input string nm);
    int n;
    int err;
    n = 0; err = 0;
    lk_req = 1'b1; upd_valid = 1'b1; upd_pc = 32'h0000_5550; upd_target = 32'h1;
    while (n < 2000) begin
      @(negedge clk);
      if (flush_busy !== 1'b1) break;
      if (arr_en !== 1'b1 || arr_we !== 1'b1 || arr_wvalid !== 1'b0 ||
          arr_idx !== n[IDX_W-1:0] || arr_wtag !== '0 || arr_wtarget !== '0 ||
          lk_gnt !== 1'b0 || upd_ready !== 1'b0) err++;
      n++;
      cyc();
      flush_req = (n == 500);
      if (n == 1024) begin lk_req = 1'b0; upd_valid = 1'b0; end
    end
    check({nm, "_len"}, n, 1024);
    check({nm, "_seq"}, err, 0);
    check({nm, "_ready_after"}, upd_ready, 1);
  endtask

  // Full-priority table: updates offered while lk_req stays high on pc 0x4000 (idx 0, tag 4).
  localparam logic [31:0] FP_PC  [7] = '{32'h10040, 32'h10044, 32'h10048, 32'h1004C, 32'h10050, 32'h10050, 32'h0};
  localparam logic [9:0]  FP_IDX [7] = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h014, 10'h014, 10'h000};
  localparam bit FP_V   [7] = '{1, 1, 1, 1, 1, 1, 0};
  localparam bit FP_RDY [7] = '{1, 1, 1, 1, 0, 1, 0};
  localparam bit FP_GNT [7] = '{1, 1, 1, 1, 0, 1, 0};
  localparam bit FP_WE  [7] = '{0, 0, 0, 0, 1, 0, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, with requests present that must be masked.
    lk_req = 1'b1; flush_req = 1'b1; upd_valid = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    check("rst_flush_busy", flush_busy, 1);
    check("rst_pred_valid", pred_valid, 0);
    check("rst_pred_hit", pred_hit, 0);
    check("rst_pred_target", pred_target, 0);
    check("rst_lk_gnt", lk_gnt, 0);
    check("rst_upd_ready", upd_ready, 0);
    check("rst_arr_en", arr_en, 0);
    check("rst_arr_we", arr_we, 0);
    cyc(); rst_n = 1'b1; flush_req = 1'b0;
    run_sweep("reset_sweep");

    // Hit path: 0x1230 -> idx 0x08C, tag 0x1.
    cyc(); upd_valid = 1'b1; upd_pc = 32'h0000_1230; upd_target = 32'h0000_2000;
    push_wr(10'h08C, 20'h1, 32'h0000_2000);
    @(negedge clk); check("hit_enq_ready", upd_ready, 1);
    cyc(); upd_valid = 1'b0;
    @(negedge clk); check("hit_drain_we", arr_we, 1);
    lookup(32'h0000_1230, 1'b1, 32'h0000_2000, "hit_gnt");
    lookup(32'h0000_2230, 1'b0, 32'h0, "alias_gnt");
    lookup(32'h0000_0000, 1'b0, 32'h0, "cold_gnt");
    cyc(); @(negedge clk); check("pred_idle", pred_valid, 0);

    // Queue full takes the port from a held lookup.
    lk_pc = 32'h0000_4000;
    for (int k = 0; k < 7; k++) begin
      cyc(); lk_req = 1'b1; upd_valid = FP_V[k]; upd_pc = FP_PC[k]; upd_target = 32'hA000_0000 + k;
      if (FP_V[k] && FP_RDY[k]) push_wr(FP_IDX[k], 20'h10, 32'hA000_0000 + k);
      if (FP_GNT[k]) push_lk(1'b0, 32'h0);
      @(negedge clk);
      check($sformatf("full_gnt_%0d", k), lk_gnt, FP_GNT[k]);
      check($sformatf("full_rdy_%0d", k), upd_ready, FP_RDY[k]);
      check($sformatf("full_we_%0d", k), arr_we, FP_WE[k]);
    end
    cyc(); lk_req = 1'b0; upd_valid = 1'b0;
    repeat (5) cyc();
    check("full_all_drained", wr_q.size(), 0);

    // Starvation: one queued update, lookups of 0x1230 held; drain after 8 waiting grants.
    for (int k = 0; k < 11; k++) begin
      cyc(); lk_req = 1'b1; lk_pc = 32'h0000_1230;
      upd_valid = (k == 0); upd_pc = 32'h0002_0080; upd_target = 32'h0000_3000;
      if (k == 0) push_wr(10'h020, 20'h20, 32'h0000_3000);
      if (k != 9) push_lk(1'b1, 32'h0000_2000);
      @(negedge clk);
      check($sformatf("starve_gnt_%0d", k), lk_gnt, (k != 9));
      check($sformatf("starve_we_%0d", k), arr_we, (k == 9));
    end
    cyc(); lk_req = 1'b0; upd_valid = 1'b0;
    @(negedge clk);

    // Flush with three updates queued: none may be written.
    for (int k = 0; k < 3; k++) begin
      cyc(); lk_req = 1'b1; lk_pc = 32'h0;
      upd_valid = 1'b1; upd_pc = 32'h0003_0100 + 4 * k; upd_target = 32'hB000_0000 + k;
      push_lk(1'b0, 32'h0);
      @(negedge clk);
      check($sformatf("fl_gnt_%0d", k), lk_gnt, 1);
      check($sformatf("fl_rdy_%0d", k), upd_ready, 1);
    end
    cyc(); upd_valid = 1'b0; flush_req = 1'b1;
    @(negedge clk);
    check("fl_req_gnt", lk_gnt, 0);
    check("fl_req_arr_en", arr_en, 0);
    check("fl_req_busy", flush_busy, 0);
    cyc(); flush_req = 1'b0;
    run_sweep("flush_sweep");
    lookup(32'h0000_1230, 1'b0, 32'h0, "post_flush_a");
    lookup(32'h0001_0040, 1'b0, 32'h0, "post_flush_b");
    lookup(32'h0002_0080, 1'b0, 32'h0, "post_flush_c");
    lookup(32'h0003_0100, 1'b0, 32'h0, "post_flush_d");

    // Normal operation resumes after a flush.
    cyc(); upd_valid = 1'b1; upd_pc = 32'h0003_0100; upd_target = 32'h0000_4444;
    push_wr(10'h040, 20'h30, 32'h0000_4444);
    cyc(); upd_valid = 1'b0;
    cyc();
    lookup(32'h0003_0100, 1'b1, 32'h0000_4444, "refill_gnt");

    // Reset in the middle of draining: second update is lost, sweep restarts at 0.
    cyc(); upd_valid = 1'b1; upd_pc = 32'h0000_1230; upd_target = 32'h0000_5555;
    push_wr(10'h08C, 20'h1, 32'h0000_5555);
    cyc(); upd_pc = 32'h0000_2230; upd_target = 32'h0000_6666;
    @(negedge clk); check("mid_drain_we", arr_we, 1);
    cyc(); upd_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_arr_en", arr_en, 0);
    check("mid_rst_upd_ready", upd_ready, 0);
    cyc(); rst_n = 1'b1;
    run_sweep("rerst_sweep");
    lookup(32'h0000_1230, 1'b0, 32'h0, "rerst_a");
    lookup(32'h0000_2230, 1'b0, 32'h0, "rerst_b");

    repeat (3) cyc();
    check("sb_wr_left", wr_q.size(), 0);
    check("sb_lk_left", lk_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
